// File: rtl/stencil_pkg.sv
// Shared types and helpers for the stencil frame buffer.
// FSM state encoding and {y, x} address packing.
package stencil_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  function automatic logic [31:0] pack_addr(
    input logic [31:0] y,
    input logic [31:0] x,
    input int          xw
  );
    return (y << xw) | x;
  endfunction

endpackage

// File: rtl/stencil_ram.sv
// Simple dual-port RAM, synchronous read-first, per-bit write mask.
// Storage is never reset; only the read register is.
module stencil_ram #(
  parameter int DW = 12,
  parameter int AW = 10
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] wmask,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    end
  end

  // Non-blocking update above makes a same-edge read return old data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/stencil_framebuf.sv
// Stencil frame buffer with a full-buffer clear sweep FSM.
// Optional per-bit write mask port when STENCIL_WMASK_EN is defined.
module stencil_framebuf
  import stencil_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int X_WIDTH     = 5,
  parameter int Y_WIDTH     = 5,
  parameter int RESET_CLEAR = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [X_WIDTH-1:0]    wr_x,
  input  logic [Y_WIDTH-1:0]    wr_y,
  input  logic [DATA_WIDTH-1:0] wr_data,
`ifdef STENCIL_WMASK_EN
  input  logic [DATA_WIDTH-1:0] wr_mask,
`endif
  input  logic                  rd_en,
  input  logic [X_WIDTH-1:0]    rd_x,
  input  logic [Y_WIDTH-1:0]    rd_y,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clear_req,
  input  logic [DATA_WIDTH-1:0] clear_value,
  output logic                  busy,
  output logic                  clear_done
);

  localparam int AW = X_WIDTH + Y_WIDTH;
  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  state_t state, state_nx;
  logic [AW:0] cnt;
  logic [DATA_WIDTH-1:0] fill;
  logic boot;
  logic start, last;

  logic ram_we;
  logic [AW-1:0] ram_waddr, wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_wmask, ext_mask;

`ifdef STENCIL_WMASK_EN
  assign ext_mask = wr_mask;
`else
  assign ext_mask = '1;
`endif

  assign wr_addr = AW'(pack_addr(32'(wr_y), 32'(wr_x), X_WIDTH));
  assign rd_addr = AW'(pack_addr(32'(rd_y), 32'(rd_x), X_WIDTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (boot || clear_req) begin
          start    = 1'b1;
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        if (cnt == LAST) begin
          last     = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  // boot requests the one-shot post-reset sweep with a zero fill.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      fill       <= '0;
      boot       <= 1'(RESET_CLEAR);
      clear_done <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      boot       <= 1'b0;
      clear_done <= last;
      rd_valid   <= rd_en;
      if (start) begin
        cnt  <= '0;
        fill <= boot ? '0 : clear_value;
      end else if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy = (state == CLEAR);

  always_comb begin
    ram_we    = wr_en;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    ram_wmask = ext_mask;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = cnt[AW-1:0];
      ram_wdata = fill;
      ram_wmask = '1;
    end
  end

  stencil_ram #(
    .DW (DATA_WIDTH),
    .AW (AW)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .wmask   (ram_wmask),
    .re      (rd_en),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

endmodule

// File: tb/tb_stencil_framebuf.sv
// Self-checking bench for stencil_framebuf: vector table, random
// traffic against an array model, and clear/reset sequences.
module tb_stencil_framebuf;

  localparam int DW = 12;
  localparam int XW = 5;
  localparam int YW = 5;
  localparam int DEPTH = 1 << (XW + YW);

  logic clock = 1'b0;
  logic reset_n;
  logic wr_en;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [DW-1:0] wr_data;
`ifdef STENCIL_WMASK_EN
  logic [DW-1:0] wr_mask;
`endif
  logic rd_en;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [DW-1:0] rd_data;
  logic rd_valid;
  logic clear_req;
  logic [DW-1:0] clear_value;
  logic busy;
  logic clear_done;

  int n_cmp = 0;
  int n_bad = 0;

  int  model [DEPTH];
  bit  known [DEPTH];

  stencil_framebuf #(
    .DATA_WIDTH  (DW),
    .X_WIDTH     (XW),
    .Y_WIDTH     (YW),
    .RESET_CLEAR (0)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data     (wr_data),
`ifdef STENCIL_WMASK_EN
    .wr_mask     (wr_mask),
`endif
    .rd_en       (rd_en),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .clear_req   (clear_req),
    .clear_value (clear_value),
    .busy        (busy),
    .clear_done  (clear_done)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    bit we; int wx; int wy; int wd;
    bit re; int rx; int ry;
    int exp_valid; int exp_data;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, then wait for the following negedge.
  task automatic step(input bit we, input int wx, input int wy,
                      input int wd, input bit re, input int rx,
                      input int ry);
    wr_en   = we;
    wr_x    = XW'(wx);
    wr_y    = YW'(wy);
    wr_data = DW'(wd);
    rd_en   = re;
    rd_x    = XW'(rx);
    rd_y    = YW'(ry);
    if (we) begin
      model[wy * 32 + wx] = wd & 'hFFF;
      known[wy * 32 + wx] = 1'b1;
    end
    @(negedge clock);
  endtask

  initial begin
    int n, dones, a, exp_d;
    bit exp_k;
    reset_n = 1'b0;
    wr_en = 0; wr_x = 0; wr_y = 0; wr_data = 0;
`ifdef STENCIL_WMASK_EN
    wr_mask = '1;
`endif
    rd_en = 0; rd_x = 0; rd_y = 0;
    clear_req = 0; clear_value = 0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    #1;
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clear_done", 32'(clear_done), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("no_boot_sweep", 32'(busy), 0);

    tbl[0] = '{1, 3, 5, 'hABC, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 1, 3, 5, 1, 'hABC};
    tbl[2] = '{1, 7, 7, 'h111, 0, 0, 0, 0, 'hABC};
    tbl[3] = '{1, 7, 7, 'h222, 1, 7, 7, 1, 'h111};
    tbl[4] = '{0, 0, 0, 0, 1, 7, 7, 1, 'h222};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 'h222};
    tbl[6] = '{1, 31, 31, 'hFFF, 1, 3, 5, 1, 'hABC};
    tbl[7] = '{0, 0, 0, 0, 1, 31, 31, 1, 'hFFF};
    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].wx, tbl[i].wy, tbl[i].wd,
           tbl[i].re, tbl[i].rx, tbl[i].ry);
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid),
          tbl[i].exp_valid);
      chk($sformatf("vec%0d_data", i), 32'(rd_data), tbl[i].exp_data);
    end

    // Random traffic on a small window to force read/write collisions.
    exp_d = 'hFFF;
    exp_k = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bit we, re;
      int wx, wy, wd, rx, ry;
      we = 1'($urandom);
      re = 1'($urandom);
      wx = $urandom_range(0, 3);
      wy = $urandom_range(0, 3);
      wd = $urandom_range(0, 4095);
      rx = $urandom_range(0, 3);
      ry = $urandom_range(0, 3);
      if (re) begin
        a = ry * 32 + rx;
        exp_k = known[a];
        exp_d = model[a];
      end
      step(we, wx, wy, wd, re, rx, ry);
      chk("rand_valid", 32'(rd_valid), 32'(re));
      if (exp_k) chk("rand_data", 32'(rd_data), exp_d);
    end

    // Full clear with a write and a second request injected mid-sweep.
    clear_req = 1'b1;
    clear_value = 'h5A5;
    step(0, 0, 0, 0, 0, 0, 0);
    clear_req = 1'b0;
    clear_value = 0;
    chk("clear_busy_start", 32'(busy), 1);
    n = 0;
    dones = 0;
    while (busy && n < 2000) begin
      n++;
      if (n == 500) begin
        clear_req = 1'b1;
        clear_value = 'h777;
        wr_en = 1; wr_x = 4; wr_y = 2; wr_data = 'h123;
      end else begin
        clear_req = 1'b0;
        wr_en = 0;
      end
      @(negedge clock);
      if (clear_done) dones++;
    end
    wr_en = 0;
    clear_req = 0;
    chk("clear_busy_cycles", n, 1024);
    chk("clear_done_pulses", dones, 1);
    @(negedge clock);
    chk("clear_done_single", 32'(clear_done), 0);
    chk("clear_idle", 32'(busy), 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 0, 1, i % 32, i / 32);
      chk($sformatf("clear_rd_%0d", i), 32'(rd_data), 'h5A5);
      model[i] = 'h5A5;
      known[i] = 1'b1;
    end

    // Reset in the middle of a sweep.
    step(1, 20, 15, 'h3C3, 0, 0, 0);
    clear_req = 1'b1;
    clear_value = 'h0F0;
    step(0, 0, 0, 0, 0, 0, 0);
    clear_req = 1'b0;
    for (int i = 0; i < 100; i++) @(negedge clock);
    chk("sweep_busy_at_100", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rd_data", 32'(rd_data), 0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_clear_done", 32'(clear_done), 0);
    @(negedge clock);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (clear_done || busy) dones++;
    end
    chk("post_rst_quiet", dones, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("partial_addr0", 32'(rd_data), 'h0F0);
    step(0, 0, 0, 0, 1, 20, 15);
    chk("partial_addr500", 32'(rd_data), 'h3C3);
    step(0, 0, 0, 0, 1, 31, 31);
    chk("partial_addr1023", 32'(rd_data), 'h5A5);

`ifdef STENCIL_WMASK_EN
    wr_mask = '1;
    step(1, 1, 1, 'hFFF, 0, 0, 0);
    wr_mask = 'h0F0;
    step(1, 1, 1, 'h000, 0, 0, 0);
    wr_mask = '1;
    step(0, 0, 0, 0, 1, 1, 1);
    chk("wmask_merge", 32'(rd_data), 'hF0F);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stencil_framebuf.md
STENCIL_FRAMEBUF -- requirements
Module: stencil_framebuf

Interface
REQ-001 Parameter DATA_WIDTH, default 12, sets the bit width of one stencil entry.
REQ-002 Parameter X_WIDTH, default 5, sets the column address width.
REQ-003 Parameter Y_WIDTH, default 5, sets the row address width; DEPTH = 2^(X_WIDTH+Y_WIDTH); linear address = {y, x}.
REQ-004 Parameter RESET_CLEAR, default 0; when 1, a clear sweep starts automatically on the first clock edge after reset release.
REQ-005 Port clock, input, 1 bit: single clock, rising edge.
REQ-006 Port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port wr_en, input, 1 bit: write request.
REQ-008 Ports wr_x and wr_y, inputs, X_WIDTH and Y_WIDTH bits: write coordinate.
REQ-009 Port wr_data, input, DATA_WIDTH bits: write value.
REQ-010 Port rd_en, input, 1 bit: read request.
REQ-011 Ports rd_x and rd_y, inputs, X_WIDTH and Y_WIDTH bits: read coordinate.
REQ-012 Port rd_data, output, DATA_WIDTH bits: registered read result.
REQ-013 Port rd_valid, output, 1 bit: rd_data holds the result of the previous accepted read.
REQ-014 Port clear_req, input, 1 bit: request a full-buffer fill.
REQ-015 Port clear_value, input, DATA_WIDTH bits: fill value, sampled on the accepting edge.
REQ-016 Port busy, output, 1 bit: a clear sweep is in progress.
REQ-017 Port clear_done, output, 1 bit: single-cycle pulse when a sweep completes.

Function
REQ-018 Reads shall have 1-cycle latency: when rd_en=1 at edge N, rd_data and rd_valid=1 shall be presented after edge N; when rd_en=0, rd_valid shall be 0 and rd_data shall hold its last value.
REQ-019 Same-address read and write in the same cycle shall be read-first: rd_data returns the pre-write contents.
REQ-020 The FSM shall have exactly two states: IDLE and CLEAR.
REQ-021 In IDLE, clear_req=1 shall latch clear_value, zero the sweep counter, and enter CLEAR.
REQ-022 In CLEAR, one address per cycle shall be written with the latched value, in order 0 to DEPTH-1, for DEPTH cycles; busy=1 throughout.
REQ-023 After writing address DEPTH-1, the FSM shall return to IDLE with busy=0 and pulse clear_done for exactly one cycle.
REQ-024 During CLEAR, external writes shall be dropped and clear_req ignored; reads shall still be served and may return either pre- or post-clear data.
REQ-025 The sweep counter shall be X_WIDTH+Y_WIDTH+1 bits wide, and addresses shall not wrap.

Reset
REQ-026 While reset_n=0: rd_data=0, rd_valid=0, busy=0, clear_done=0, FSM=IDLE, counter=0.
REQ-027 Memory contents shall not be reset, and a reset during CLEAR shall leave the memory partially cleared without producing a clear_done pulse.
REQ-028 When RESET_CLEAR=1, the post-reset sweep shall use fill value 0.

Configuration
REQ-029 Macro STENCIL_WMASK_EN defined: the block shall add input port wr_mask (DATA_WIDTH bits), and an external write shall store (old & ~wr_mask) | (wr_data & wr_mask) in the same cycle.
REQ-030 Macro STENCIL_WMASK_EN undefined: the wr_mask port shall be absent and the full word shall be written; clear sweeps shall always write the full word.

Structure
REQ-031 Package stencil_pkg shall hold the FSM state type and the address-packing function {y, x}.
REQ-032 Sub-module stencil_ram (simple dual-port RAM, synchronous read-first, optional bit mask) shall hold the storage; the FSM, counter and port muxing shall reside in stencil_framebuf.

Verification
REQ-033 Write (3,5)=0xABC, then read (3,5) on the next cycle -> rd_data=0xABC with rd_valid=1 exactly one cycle after rd_en.
REQ-034 Hold (7,7)=0x111; write 0x222 and read (7,7) in the same cycle -> rd_data=0x111; read again -> 0x222.
REQ-035 clear_req with clear_value=0x5A5 (defaults) -> busy=1 for 1024 cycles, one clear_done pulse, all addresses read 0x5A5; a write issued mid-sweep is lost.
REQ-036 Assert reset_n=0 at sweep cycle 100 -> all outputs 0 and no clear_done; address 0 reads the fill value and address 500 reads its old value.
REQ-037 With STENCIL_WMASK_EN: old=0xFFF, wr_data=0x000, wr_mask=0x0F0 -> readback 0xF0F.
